// File: rtl/sweep_capture_engine_pkg.sv
// sweep_pkg: shared mode/state enums and the idx-to-pattern map for the sweep engine
package sweep_pkg;
  typedef enum logic [1:0] {UP, DOWN, GRAY} sweep_mode_e;
  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, DONE} sweep_state_e;
  function automatic sweep_mode_e mode_dec(logic [1:0] m);
    return m == 2'b01 ? DOWN : m == 2'b10 ? GRAY : UP;
  endfunction
  function automatic logic [15:0] pat_map(sweep_mode_e m, logic [15:0] idx, logic [15:0] top);
    return m == DOWN ? top - idx : m == GRAY ? idx ^ (idx >> 1) : idx;
  endfunction
endpackage

// File: rtl/sweep_capture_engine_if.sv
// sweep_capture_engine_if: stimulus/record/status bundle; master=engine (drives n_out, rec_*, busy, done, signature), slave=bench/sink
interface sweep_capture_engine_if #(parameter int W = 4, parameter int OW = 1, parameter int SIG_W = 16);
  logic             start;
  logic [1:0]       mode;
  logic [W-1:0]     n_out;
  logic [OW-1:0]    dut_resp;
  logic             rec_valid;
  logic             rec_ready;
  logic [W-1:0]     rec_pattern;
  logic [OW-1:0]    rec_resp;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  modport master(input start, mode, dut_resp, rec_ready,
                 output n_out, rec_valid, rec_pattern, rec_resp, busy, done, signature);
  modport slave(output start, mode, dut_resp, rec_ready,
                input n_out, rec_valid, rec_pattern, rec_resp, busy, done, signature);
endinterface

// File: rtl/sweep_capture_engine_misr.sv
// misr_compactor: SIG_W-bit MISR folding din on en; clear/reset load SEED (ports CK, reset, clear, en, din -> sig)
module misr_compactor #(
  parameter int               SIG_W = 16,
  parameter int               OW    = 1,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [OW-1:0]    din,
  output logic [SIG_W-1:0] sig
);
  always_ff @(posedge CK) begin
    if (reset || clear) sig <= SEED;
    else if (en) sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
  end
endmodule

// File: rtl/sweep_capture_engine.sv
// sweep_capture_engine: sweeps all 2**W patterns, holds HOLD cycles, emits {pattern,resp} records and a MISR signature (ports CK, reset, bus master)
module sweep_capture_engine
  import sweep_pkg::*;
#(
  parameter int               W     = 4,
  parameter int               OW    = 1,
  parameter int               HOLD  = 1,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input logic                    CK,
  input logic                    reset,
  sweep_capture_engine_if.master bus
);
  localparam int          HW  = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam logic [15:0] TOP = 16'((32'd1 << W) - 32'd1);
  sweep_state_e     r_state, w_next;
  sweep_mode_e      r_mode;
  logic [W-1:0]     r_idx, r_nout, r_rec_pattern;
  logic [HW-1:0]    r_hold;
  logic             r_rec_valid;
  logic [OW-1:0]    r_rec_resp;
  logic [SIG_W-1:0] w_sig;
  logic             w_start, w_acc, w_last;
  assign w_start = r_state == IDLE && bus.start;
  assign w_acc   = r_state == EMIT && bus.rec_ready;
  assign w_last  = r_idx == '1;
  always_ff @(posedge CK) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE   ? (bus.start ? SETTLE : IDLE) :
             r_state == SETTLE ? (r_hold == '0 ? EMIT : SETTLE) :
             r_state == EMIT   ? (!bus.rec_ready ? EMIT : w_last ? DONE : SETTLE) :
             IDLE;
  end
  always_comb begin
    bus.busy = r_state == SETTLE || r_state == EMIT;
    bus.done = r_state == DONE;
  end
  always_ff @(posedge CK) begin
    if (reset) begin
      r_mode        <= UP;
      r_idx         <= '0;
      r_nout        <= '0;
      r_hold        <= '0;
      r_rec_valid   <= 1'b0;
      r_rec_pattern <= '0;
      r_rec_resp    <= '0;
    end else begin
      if (w_start) begin
        r_mode <= mode_dec(bus.mode);
        r_idx  <= '0;
        r_nout <= W'(pat_map(mode_dec(bus.mode), 16'd0, TOP));
        r_hold <= HW'(HOLD - 1);
      end
      if (r_state == SETTLE) begin
        if (r_hold == '0) begin
          r_rec_valid   <= 1'b1;
          r_rec_pattern <= r_nout;
          r_rec_resp    <= bus.dut_resp;
        end else r_hold <= r_hold - 1'b1;
      end
      if (w_acc) begin
        r_rec_valid <= 1'b0;
        if (!w_last) begin
          r_idx  <= r_idx + 1'b1;
          r_nout <= W'(pat_map(r_mode, 16'(r_idx) + 16'd1, TOP));
          r_hold <= HW'(HOLD - 1);
        end
      end
    end
  end
  misr_compactor #(.SIG_W(SIG_W), .OW(OW), .POLY(POLY), .SEED(SEED)) u_misr (
    .CK(CK), .reset(reset), .clear(w_start), .en(w_acc), .din(r_rec_resp), .sig(w_sig)
  );
  assign bus.n_out       = r_nout;
  assign bus.rec_valid   = r_rec_valid;
  assign bus.rec_pattern = r_rec_pattern;
  assign bus.rec_resp    = r_rec_resp;
  assign bus.signature   = w_sig;
endmodule

// File: tb/tb_sweep_capture_engine.sv
// tb_sweep_capture_engine: randomized sweeps of HOLD=1 and HOLD=3 engines checked against a pattern-list/MISR reference model
module tb_sweep_capture_engine;
  localparam int          W = 4, OW = 1, SIG_W = 16, N = 16;
  localparam logic [15:0] POLY = 16'h1021;
  logic CK = 0, reset = 1;
  always #5 CK = ~CK;
  sweep_capture_engine_if #(.W(W), .OW(OW), .SIG_W(SIG_W)) b1 ();
  sweep_capture_engine_if #(.W(W), .OW(OW), .SIG_W(SIG_W)) b3 ();
  sweep_capture_engine #(.W(W), .OW(OW), .HOLD(1), .SIG_W(SIG_W), .POLY(POLY), .SEED('0)) u1 (
    .CK(CK), .reset(reset), .bus(b1));
  sweep_capture_engine #(.W(W), .OW(OW), .HOLD(3), .SIG_W(SIG_W), .POLY(POLY), .SEED('0)) u3 (
    .CK(CK), .reset(reset), .bus(b3));
  logic [OW-1:0] resp_tbl [N];
  assign b1.dut_resp  = resp_tbl[b1.n_out];
  assign b3.dut_resp  = resp_tbl[b3.n_out];
  assign b3.start     = b1.start;
  assign b3.mode      = b1.mode;
  assign b3.rec_ready = b1.rec_ready;
  logic sel = 0;
  logic [W-1:0] o_n, o_rp;
  logic [OW-1:0] o_rr;
  logic o_v, o_busy, o_done;
  logic [SIG_W-1:0] o_sig;
  always_comb begin
    o_n    = sel ? b3.n_out : b1.n_out;
    o_rp   = sel ? b3.rec_pattern : b1.rec_pattern;
    o_rr   = sel ? b3.rec_resp : b1.rec_resp;
    o_v    = sel ? b3.rec_valid : b1.rec_valid;
    o_busy = sel ? b3.busy : b1.busy;
    o_done = sel ? b3.done : b1.done;
    o_sig  = sel ? b3.signature : b1.signature;
  end
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] ref_pat(input logic [1:0] m, input int i);
    if (m == 2'b01) return W'(N - 1 - i);
    if (m == 2'b10) return W'(i ^ (i >> 1));
    return W'(i);
  endfunction
  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [OW-1:0] r);
    logic [15:0] t;
    t = s << 1;
    return t ^ (s[15] ? POLY : 16'h0) ^ 16'(r);
  endfunction
  task automatic check_reset_state(input string tag);
    chk({tag, "_nout"}, o_n, 0);
    chk({tag, "_valid"}, o_v, 0);
    chk({tag, "_rpat"}, o_rp, 0);
    chk({tag, "_rresp"}, o_rr, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_sig"}, o_sig, 0);
  endtask
  task automatic wait_idle();
    int n = 0;
    b1.start = 0;
    b1.rec_ready = 1;
    while ((b1.busy || b3.busy || b1.done || b3.done) && n < 3000) begin
      @(negedge CK);
      n++;
    end
    chk("idle_wait", n < 3000, 1);
  endtask
  // rdy: 0 always ready, 1 random ready, 2 stall record stall_k for 5 cycles
  task automatic run_sweep(input logic [1:0] m, input int hold, input int rdy, input int stall_k,
                           input int abort_k, input bit keep_start, output logic [15:0] sig_out);
    int k = 0, cyc = 0, last = 0, stall = 0;
    logic [15:0] ms = 0;
    logic [W-1:0] prev_p = 0, ep;
    bit prev_v = 0, fin = 0, all_rdy = 1, r;
    wait_idle();
    sel = hold == 3;
    sig_out = 0;
    @(negedge CK);
    b1.start = 1;
    b1.mode = m;
    b1.rec_ready = 0;
    while (!fin && cyc < 4000) begin
      @(negedge CK);
      cyc++;
      if (!keep_start) b1.start = 0;
      if (abort_k >= 0 && k == abort_k && o_v) begin
        reset = 1;
        b1.start = 0;
        @(negedge CK);
        check_reset_state("abort");
        reset = 0;
        return;
      end
      chk("sig", o_sig, ms);
      if (o_done) begin
        chk("done_cnt", k, N);
        chk("busy_at_done", o_busy, 0);
        if (all_rdy) chk("done_cyc", cyc, N * (hold + 1) + 1);
        sig_out = o_sig;
        fin = 1;
      end else begin
        chk("busy", o_busy, 1);
        if (o_v) begin
          if (!prev_v) chk("latency", cyc - last, hold + 1);
          else chk("hold_pat", o_rp, prev_p);
          chk("nout_eq", o_n, o_rp);
          r = rdy == 0 ? 1'b1 : rdy == 1 ? ($urandom_range(0, 99) < 70) : !(k == stall_k && stall < 5);
          if (!r) all_rdy = 0;
          if (rdy == 2 && !r) stall++;
          b1.rec_ready = r;
          if (r) begin
            ep = ref_pat(m, k);
            chk("pat", o_rp, ep);
            chk("resp", o_rr, resp_tbl[ep]);
            ms = ref_misr(ms, resp_tbl[ep]);
            k++;
            last = cyc;
          end
          prev_p = o_rp;
        end else b1.rec_ready = 1'($urandom_range(0, 1));
        prev_v = o_v;
      end
    end
    chk("timeout", fin, 1);
    if (rdy == 2) chk("stall_cycles", stall, 5);
    @(negedge CK);
    chk("post_done", o_done, 0);
    chk("post_busy", o_busy, 0);
    b1.start = 0;
    @(negedge CK);
    chk("no_restart", o_busy, 0);
  endtask
  initial begin
    logic [15:0] s, s1;
    b1.start = 0;
    b1.mode = 0;
    b1.rec_ready = 0;
    for (int i = 0; i < N; i++) resp_tbl[i] = OW'(i >> 3);
    repeat (3) @(negedge CK);
    check_reset_state("rst");
    reset = 0;
    run_sweep(2'b00, 1, 0, -1, -1, 0, s1);
    run_sweep(2'b10, 1, 0, -1, -1, 0, s);
    run_sweep(2'b01, 1, 0, -1, -1, 0, s);
    run_sweep(2'b11, 1, 0, -1, -1, 0, s);
    run_sweep(2'b00, 1, 2, 2, -1, 0, s);
    for (int i = 0; i < N; i++) resp_tbl[i] = 0;
    run_sweep(2'b00, 1, 0, -1, -1, 0, s);
    chk("sig_zero", s, 16'h0000);
    resp_tbl[N-1] = 1;
    run_sweep(2'b00, 1, 0, -1, -1, 0, s);
    chk("sig_one", s, 16'h0001);
    for (int i = 0; i < N; i++) resp_tbl[i] = OW'(i >> 3);
    run_sweep(2'b00, 1, 0, -1, 7, 0, s);
    run_sweep(2'b00, 1, 0, -1, -1, 0, s);
    chk("restart_sig", s, s1);
    run_sweep(2'b00, 1, 0, -1, -1, 1, s);
    run_sweep(2'b00, 3, 0, -1, -1, 1, s);
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) resp_tbl[i] = OW'($urandom_range(0, 1));
      run_sweep(2'($urandom_range(0, 3)), it % 2 ? 3 : 1, 1, -1, -1, it == 5, s);
    end
    run_sweep(2'b10, 3, 2, 4, -1, 0, s);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
